// File: rtl/fusion_seq.sv
// Dot-product sequencer for a single fusion unit: latches config, streams operand pairs, accumulates psums.
// Optional saturating accumulator enabled by defining FUSION_SEQ_SAT_EN; default build wraps modulo 2^ACC_W.
module fusion_seq #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       cfg_in_width,
  input  logic [2:0]       cfg_weight_width,
  input  logic             cfg_s_in,
  input  logic             cfg_s_weight,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_in,
  input  logic [3:0]       op_weight,
  output logic [3:0]       fu_in,
  output logic [3:0]       fu_weight,
  output logic [2:0]       fu_in_width,
  output logic [2:0]       fu_weight_width,
  output logic             fu_s_in,
  output logic             fu_s_weight,
  input  logic [17:0]      fu_psum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] remain;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] acc_next;
  logic             issue_q;
  logic             signed_mode;
  logic             beat;

  assign signed_mode = fu_s_in | fu_s_weight;
  assign busy        = (state != IDLE);
  assign op_ready    = (state == RUN) && (remain != '0);
  assign beat        = op_valid & op_ready;
  assign fu_in       = beat ? op_in : 4'd0;
  assign fu_weight   = beat ? op_weight : 4'd0;
  assign res_data    = acc;
  assign addend      = signed_mode ? ACC_W'(signed'(fu_psum)) : ACC_W'(fu_psum);

`ifdef FUSION_SEQ_SAT_EN
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sat_val;
  logic             ovf;
  logic             sat_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum_ext = '0;
    sat_val = '1;
    ovf     = 1'b0;
    if (signed_mode) begin
      sum_ext = {acc[ACC_W-1], acc} + {addend[ACC_W-1], addend};
      ovf     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
      sat_val = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum_ext = {1'b0, acc} + {1'b0, addend};
      ovf     = sum_ext[ACC_W];
    end
    // A saturated accumulator is pinned at its limit until the next job.
    acc_next = sat_q ? acc : (ovf ? sat_val : sum_ext[ACC_W-1:0]);
  end
`else
  assign acc_next = acc + addend;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      remain          <= '0;
      acc             <= '0;
      issue_q         <= 1'b0;
      res_valid       <= 1'b0;
      fu_in_width     <= '0;
      fu_weight_width <= '0;
      fu_s_in         <= 1'b0;
      fu_s_weight     <= 1'b0;
`ifdef FUSION_SEQ_SAT_EN
      sat_q           <= 1'b0;
`endif
    end else begin
      // The fusion unit's psum lags its operands by one cycle, tracked by issue_q.
      if (issue_q) begin
        acc <= acc_next;
`ifdef FUSION_SEQ_SAT_EN
        sat_q <= sat_q | ovf;
`endif
      end
      issue_q <= beat;

      case (state)
        IDLE: begin
          if (start) begin
            fu_in_width     <= cfg_in_width;
            fu_weight_width <= cfg_weight_width;
            fu_s_in         <= cfg_s_in;
            fu_s_weight     <= cfg_s_weight;
            remain          <= cfg_len;
            acc             <= '0;
            issue_q         <= 1'b0;
`ifdef FUSION_SEQ_SAT_EN
            sat_q           <= 1'b0;
`endif
            if (cfg_len != '0) begin
              state <= RUN;
            end else begin
              state     <= DONE;
              res_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (beat) begin
            remain <= remain - LEN_W'(1);
            if (remain == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          state     <= DONE;
          res_valid <= 1'b1;
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fusion_seq.sv
// Scoreboard bench for fusion_seq: two instances (ACC_W=32 and ACC_W=18) share one stimulus stream.
// Expected results follow FUSION_SEQ_SAT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_fusion_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [2:0]  cfg_in_width = '0, cfg_weight_width = '0;
  logic        cfg_s_in = 1'b0, cfg_s_weight = 1'b0;
  logic [11:0] cfg_len = '0;
  logic        op_valid = 1'b0;
  logic [3:0]  op_in = '0, op_weight = '0;
  logic        res_ready = 1'b0;

  logic        busy_a, op_ready_a, fu_s_in_a, fu_s_weight_a, res_valid_a;
  logic [3:0]  fu_in_a, fu_weight_a;
  logic [2:0]  fu_in_width_a, fu_weight_width_a;
  logic [17:0] psum_a;
  logic [31:0] res_data_a;

  logic        busy_b, op_ready_b, fu_s_in_b, fu_s_weight_b, res_valid_b;
  logic [3:0]  fu_in_b, fu_weight_b;
  logic [2:0]  fu_in_width_b, fu_weight_width_b;
  logic [17:0] psum_b;
  logic [17:0] res_data_b;

  fusion_seq #(.LEN_W(12), .ACC_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
    .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_len(cfg_len),
    .busy(busy_a), .op_valid(op_valid), .op_ready(op_ready_a),
    .op_in(op_in), .op_weight(op_weight),
    .fu_in(fu_in_a), .fu_weight(fu_weight_a),
    .fu_in_width(fu_in_width_a), .fu_weight_width(fu_weight_width_a),
    .fu_s_in(fu_s_in_a), .fu_s_weight(fu_s_weight_a), .fu_psum(psum_a),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a)
  );

  fusion_seq #(.LEN_W(12), .ACC_W(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
    .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_len(cfg_len),
    .busy(busy_b), .op_valid(op_valid), .op_ready(op_ready_b),
    .op_in(op_in), .op_weight(op_weight),
    .fu_in(fu_in_b), .fu_weight(fu_weight_b),
    .fu_in_width(fu_in_width_b), .fu_weight_width(fu_weight_width_b),
    .fu_s_in(fu_s_in_b), .fu_s_weight(fu_s_weight_b), .fu_psum(psum_b),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b)
  );

  // Behavioural fusion unit: operand width 4 when encoded 3'b100, else low 2 bits.
  function automatic longint prod(input logic [3:0] a, input logic [3:0] b,
                                  input logic [2:0] iw, input logic [2:0] ww,
                                  input logic si, input logic sw);
    longint va, vb;
    logic [1:0] a2, b2;
    a2 = a[1:0];
    b2 = b[1:0];
    if (iw == 3'b100) va = si ? longint'($signed(a)) : longint'(a);
    else              va = si ? longint'($signed(a2)) : longint'(a2);
    if (ww == 3'b100) vb = sw ? longint'($signed(b)) : longint'(b);
    else              vb = sw ? longint'($signed(b2)) : longint'(b2);
    return va * vb;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_a <= '0;
      psum_b <= '0;
    end else begin
      psum_a <= 18'(prod(fu_in_a, fu_weight_a, fu_in_width_a, fu_weight_width_a, fu_s_in_a, fu_s_weight_a));
      psum_b <= 18'(prod(fu_in_b, fu_weight_b, fu_in_width_b, fu_weight_width_b, fu_s_in_b, fu_s_weight_b));
    end
  end

  typedef struct {
    longint sum;
    bit     sgn;
  } sb_t;
  sb_t sb[$];

  function automatic logic [63:0] exp_for(input longint s, input bit sgn, input int w);
`ifdef FUSION_SEQ_SAT_EN
    longint hi, lo;
    if (sgn) begin
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
    end else begin
      hi = (longint'(1) <<< w) - 1;
      lo = 0;
    end
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`endif
    return 64'(s) & ((64'd1 << w) - 64'd1);
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after the result handshake.
  task automatic run_job(input string name, input int len,
                         input logic [2:0] iw, input logic [2:0] ww, input logic si, input logic sw,
                         input bit rnd, input logic [3:0] ci, input logic [3:0] cw,
                         input bit stall, input int hold, input bit poke, input int exp_lat);
    logic [3:0] ai[$];
    logic [3:0] aw[$];
    longint s;
    sb_t e;
    int k, cyc;
    bit tog, extra, beat;
    s = 0;
    for (int i = 0; i < len; i++) begin
      ai.push_back(rnd ? 4'($urandom_range(0, 15)) : ci);
      aw.push_back(rnd ? 4'($urandom_range(0, 15)) : cw);
      s += prod(ai[i], aw[i], iw, ww, si, sw);
    end
    e.sum = s;
    e.sgn = si | sw;
    sb.push_back(e);

    cfg_len = 12'(len);
    cfg_in_width = iw;
    cfg_weight_width = ww;
    cfg_s_in = si;
    cfg_s_weight = sw;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (poke) begin
      cfg_len = '0;
      cfg_in_width = 3'b000;
      cfg_weight_width = 3'b000;
      cfg_s_in = ~si;
    end else begin
      start = 1'b0;
    end
    check({name, "_busy_c1"}, 64'(busy_a), 64'd1);

    k = 0;
    cyc = 1;
    tog = 1'b0;
    extra = 1'b0;
    while (!res_valid_a && cyc < 3000) begin
      op_valid = (k < len) && !(stall && tog);
      if (k < len) begin
        op_in = ai[k];
        op_weight = aw[k];
      end else begin
        op_in = 4'hF;
        op_weight = 4'hF;
      end
      #1;
      if (op_ready_a && k >= len) extra = 1'b1;
      beat = op_valid && op_ready_a;
      @(posedge clk);
      if (beat) k++;
      tog = ~tog;
      @(negedge clk);
      cyc++;
    end
    op_valid = 1'b0;

    check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({name, "_extra_ready"}, 64'(extra), 64'd0);
    check({name, "_ready_done"}, 64'(op_ready_a), 64'd0);
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      check({name, "_hold_data"}, 64'(res_data_a), exp_for(e.sum, e.sgn, 32));
      check({name, "_hold_valid"}, 64'(res_valid_a), 64'd1);
      @(negedge clk);
    end
    res_ready = 1'b1;
    check({name, "_valid_b"}, 64'(res_valid_b), 64'd1);
    check({name, "_res32"}, 64'(res_data_a), exp_for(e.sum, e.sgn, 32));
    check({name, "_res18"}, 64'(res_data_b), exp_for(e.sum, e.sgn, 18));
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    check({name, "_busy_after"}, 64'(busy_a), 64'd0);
    check({name, "_valid_after"}, 64'(res_valid_a), 64'd0);
    check({name, "_width_held"}, 64'(fu_in_width_a), 64'(iw));
  endtask

  function automatic logic [63:0] outs_a();
    return 64'({busy_a, op_ready_a, fu_in_a, fu_weight_a, fu_in_width_a, fu_weight_width_a,
                fu_s_in_a, fu_s_weight_a, res_valid_a, res_data_a});
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", outs_a(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job("uns44",  4, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 4'd3, 4'd5, 1'b0, 0, 1'b0, 6);
    run_job("sgn44",  2, 3'b100, 3'b100, 1'b1, 1'b1, 1'b0, 4'hE, 4'd3, 1'b0, 0, 1'b0, 4);
    run_job("len0",   0, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 0, 1'b0, 1);
    run_job("stall",  3, 3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 5, 1'b1, 7);
    run_job("rand2b", 6, 3'b010, 3'b010, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 0, 1'b0, 8);
    run_job("mixed",  5, 3'b100, 3'b100, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 2, 1'b0, 7);
    run_job("big", 1200, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 4'd15, 4'd15, 1'b0, 0, 1'b0, 1202);

    // Abort a job mid-RUN with reset, then confirm a clean restart.
    cfg_len = 12'd5;
    cfg_in_width = 3'b100;
    cfg_weight_width = 3'b100;
    cfg_s_in = 1'b1;
    cfg_s_weight = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b1;
    op_in = 4'd7;
    op_weight = 4'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outs", outs_a(), 64'd0);
    @(negedge clk);
    op_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_job("post_rst", 1, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2, 1'b0, 0, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
